// File: rtl/rv_mem_pkg.sv
// Shared memory-side types for the core's data port: default widths and the
// store entry layout used by the store buffer.
package rv_mem_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// Store buffer connection bundle: core-side load/store port, memory read port
// and the drain write channel towards data memory.
interface store_buffer_if
  import rv_mem_pkg::*;
#(
  parameter int AW = rv_mem_pkg::AW,
  parameter int DW = rv_mem_pkg::DW
);
  logic          MemWriteM;
  logic [AW-1:0] DataAdrM;
  logic [DW-1:0] WriteDataM;
  logic [DW-1:0] ReadDataM;
  logic          StoreStall;
  logic [AW-1:0] MemRdAdr;
  logic [DW-1:0] MemRdData;
  // Write channel: a beat transfers on a rising edge where BusWrValid and
  // BusWrReady are both 1; while BusWrValid=1 and BusWrReady=0, BusWrAdr and
  // BusWrData hold stable; BusWrValid never drops without a transfer (except reset).
  logic          BusWrValid;
  logic [AW-1:0] BusWrAdr;
  logic [DW-1:0] BusWrData;
  logic          BusWrReady;
  logic          Full;
  logic          Empty;

  modport slave (
    input  MemWriteM, DataAdrM, WriteDataM, MemRdData, BusWrReady,
    output ReadDataM, StoreStall, MemRdAdr, BusWrValid, BusWrAdr, BusWrData,
           Full, Empty
  );

  modport master (
    output MemWriteM, DataAdrM, WriteDataM, MemRdData, BusWrReady,
    input  ReadDataM, StoreStall, MemRdAdr, BusWrValid, BusWrAdr, BusWrData,
           Full, Empty
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Combinational youngest-match search over the valid store buffer entries;
// later offsets from rd_ptr are younger and win.
module sb_fwd_match
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = rv_mem_pkg::AW,
  parameter int DW    = rv_mem_pkg::DW,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic [AW-1:0] adr_i [DEPTH],
  input  logic [DW-1:0] dat_i [DEPTH],
  input  logic [PW-1:0] rd_ptr_i,
  input  logic [CW-1:0] count_i,
  input  logic [AW-1:0] lkup_adr_i,
  output logic          hit_o,
  output logic [DW-1:0] dat_o
);
  always_comb begin
    hit_o = 1'b0;
    dat_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_i) && (adr_i[rd_ptr_i + PW'(i)] == lkup_adr_i)) begin
        hit_o = 1'b1;
        dat_o = dat_i[rd_ptr_i + PW'(i)];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Word store FIFO between the core's memory stage and data memory, with
// store-to-load forwarding from the youngest buffered matching store.
module store_buffer
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = rv_mem_pkg::AW,
  parameter int DW    = rv_mem_pkg::DW
) (
  input logic         clk,
  input logic         reset,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] adr_q [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push, pop;
  logic          fwd_hit;
  logic [DW-1:0] fwd_dat;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A full buffer refuses the store even if the head drains this same cycle.
  assign push  = sb.MemWriteM & ~full;
  assign pop   = ~empty & sb.BusWrReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[wr_ptr_q] <= sb.DataAdrM;
      dat_q[wr_ptr_q] <= sb.WriteDataM;
    end
  end

  sb_fwd_match #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fwd (
    .adr_i     (adr_q),
    .dat_i     (dat_q),
    .rd_ptr_i  (rd_ptr_q),
    .count_i   (count_q),
    .lkup_adr_i(sb.DataAdrM),
    .hit_o     (fwd_hit),
    .dat_o     (fwd_dat)
  );

  assign sb.ReadDataM  = fwd_hit ? fwd_dat : sb.MemRdData;
  assign sb.StoreStall = sb.MemWriteM & full;
  assign sb.MemRdAdr   = sb.DataAdrM;
  assign sb.BusWrValid = ~empty;
  assign sb.BusWrAdr   = adr_q[rd_ptr_q];
  assign sb.BusWrData  = dat_q[rd_ptr_q];
  assign sb.Full       = full;
  assign sb.Empty      = empty;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(pop && empty));
  a_count_range:  assert property (@(posedge clk) disable iff (!reset) count_q <= CW'(DEPTH));
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_store_buffer;
  import rv_mem_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  store_buffer_if #(.AW(32), .DW(32)) sb ();

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of {adr,dat}; pushes refused when it already holds DEPTH.
  always @(posedge clk) begin
    int n;
    n = exp_q.size();
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (n > 0 && sb.BusWrReady) void'(exp_q.pop_front());
      if (sb.MemWriteM && n < DEPTH) exp_q.push_back({sb.DataAdrM, sb.WriteDataM});
    end
  end

  always @(negedge clk) begin
    int          n;
    logic [31:0] rd;
    sb_entry_t   e;
    n = exp_q.size();
    rd = sb.MemRdData;
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      if (e.adr == sb.DataAdrM) rd = e.dat;
    end
    chk("valid", 32'(sb.BusWrValid), 32'(n != 0));
    chk("empty", 32'(sb.Empty), 32'(n == 0));
    chk("full", 32'(sb.Full), 32'(n == DEPTH));
    chk("stall", 32'(sb.StoreStall), 32'(sb.MemWriteM && n == DEPTH));
    chk("rdadr", sb.MemRdAdr, sb.DataAdrM);
    chk("rdata", sb.ReadDataM, rd);
    if (n > 0) begin
      e = exp_q[0];
      chk("head_adr", sb.BusWrAdr, e.adr);
      chk("head_dat", sb.BusWrData, e.dat);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    sb.MemWriteM  = we;
    sb.DataAdrM   = adr;
    sb.WriteDataM = dat;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b0;
    sb.BusWrReady = 1'b0;
    sb.MemRdData  = 32'h0;
    drive(1'b1, 32'h40, 32'h1);

    // Reset hold with a store pending.
    step(); step();
    chk("rst_empty", 32'(sb.Empty), 32'd1);
    chk("rst_valid", 32'(sb.BusWrValid), 32'd0);
    chk("rst_full", 32'(sb.Full), 32'd0);
    reset = 1'b1;
    step();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("first_valid", 32'(sb.BusWrValid), 32'd1);
    chk("first_adr", sb.BusWrAdr, 32'h40);
    sb.BusWrReady = 1'b1;
    step();
    chk("first_drained", 32'(sb.Empty), 32'd1);

    // Single store held by backpressure.
    sb.BusWrReady = 1'b0;
    drive(1'b1, 32'h100, 32'hDEADBEEF);
    step();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(sb.BusWrValid), 32'd1);
      chk("hold_adr", sb.BusWrAdr, 32'h100);
      chk("hold_dat", sb.BusWrData, 32'hDEADBEEF);
      step();
    end
    sb.BusWrReady = 1'b1;
    step();
    chk("single_empty", 32'(sb.Empty), 32'd1);

    // Forwarding picks the youngest match.
    sb.BusWrReady = 1'b0;
    drive(1'b1, 32'h200, 32'h11); step();
    drive(1'b1, 32'h204, 32'h22); step();
    drive(1'b1, 32'h200, 32'h33); step();
    drive(1'b0, 32'h200, 32'h0);
    sb.MemRdData = 32'hAAAA;
    #1;
    chk("fwd_youngest", sb.ReadDataM, 32'h33);
    sb.DataAdrM = 32'h208;
    #1;
    chk("fwd_miss", sb.ReadDataM, 32'hAAAA);
    sb.BusWrReady = 1'b1;
    step(); step(); step();
    chk("fwd_drained", 32'(sb.Empty), 32'd1);

    // Full and stall, then release.
    sb.BusWrReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i));
      step();
    end
    chk("full_after4", 32'(sb.Full), 32'd1);
    drive(1'b1, 32'h3F0, 32'h99);
    #1;
    chk("stall5", 32'(sb.StoreStall), 32'd1);
    step();
    chk("stall_nowrite", 32'(sb.Full), 32'd1);
    chk("stall_head", sb.BusWrAdr, 32'h300);
    sb.BusWrReady = 1'b1;
    #1;
    chk("stall_with_pop", 32'(sb.StoreStall), 32'd1);
    step();
    chk("after_pop_full", 32'(sb.Full), 32'd0);
    chk("after_pop_stall", 32'(sb.StoreStall), 32'd0);
    chk("after_pop_head", sb.BusWrAdr, 32'h304);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step(); step(); step();
    chk("full_drained", 32'(sb.Empty), 32'd1);

    // Continuous drain with wrap-around: occupancy stays at one.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 32'h50 + 32'(i));
      step();
      chk("wrap_head", sb.BusWrAdr, 32'(4 * i));
      chk("wrap_notfull", 32'(sb.Full), 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("wrap_empty", 32'(sb.Empty), 32'd1);

    // Reset mid-drain discards buffered stores.
    sb.BusWrReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 32'h70 + 32'(i));
      step();
    end
    drive(1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_valid", 32'(sb.BusWrValid), 32'd0);
    chk("midrst_empty", 32'(sb.Empty), 32'd1);
    sb.DataAdrM  = 32'h500;
    sb.MemRdData = 32'h1234;
    #1;
    chk("midrst_load", sb.ReadDataM, 32'h1234);
    step();

    // Random traffic on a small address set to exercise forwarding and fullness.
    for (int blk = 0; blk < 10; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        drive($urandom_range(0, 99) < 60, {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom);
        sb.BusWrReady = $urandom_range(0, 99) < rdy_pct;
        sb.MemRdData  = $urandom;
        reset         = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    sb.BusWrReady = 1'b1;
    repeat (DEPTH + 1) step();
    chk("final_empty", 32'(sb.Empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits directly downstream of the pipelined RISC-V core's memory stage, between the core's data-memory port and the data memory.
- Accepts word stores from the core (MemWrite/DataAdr/WriteData) into a small FIFO and drains them to memory over a valid/ready write channel.
- Loads read memory combinationally; the returned data is overridden by the youngest buffered store to the same address (store-to-load forwarding).
- Raises a stall request when a store arrives while the FIFO is full.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width; stores are whole words only.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; state is cleared on a clk edge where reset==0.
- MemWriteM  in  1  core store request this cycle.
- DataAdrM  in  AW  core load/store address.
- WriteDataM  in  DW  core store data.
- ReadDataM  out  DW  load data returned to the core (combinational).
- StoreStall  out  1  store not accepted this cycle; the core must hold its M stage.
- MemRdAdr  out  AW  memory read address, equal to DataAdrM (combinational).
- MemRdData  in  DW  memory read data (combinational).
- BusWrValid  out  1  head entry is valid for draining.
- BusWrAdr  out  AW  head entry address.
- BusWrData  out  DW  head entry data.
- BusWrReady  in  1  memory accepts the head this cycle.
- Full  out  1  count==DEPTH.
- Empty  out  1  count==0.

Behaviour:
- State: entry arrays adr[DEPTH] and dat[DEPTH]; wr_ptr and rd_ptr, each clog2(DEPTH) bits and wrapping modulo DEPTH; count, clog2(DEPTH)+1 bits.
- Reset values (reset==0 at a clk edge): wr_ptr=0, rd_ptr=0, count=0. Outputs then read BusWrValid=0, Empty=1, Full=0, StoreStall=0. Entry contents are don't-care.
- Reset mid-operation discards all buffered stores, including a head being offered. BusWrValid is 0 from the next cycle.
- push = MemWriteM & ~Full. On push: adr[wr_ptr]<=DataAdrM, dat[wr_ptr]<=WriteDataM, wr_ptr increments.
- StoreStall = MemWriteM & Full. This is combinational and does not depend on BusWrReady. A store arriving while Full is refused even if a pop happens the same cycle.
- pop = BusWrValid & BusWrReady. On pop, rd_ptr increments.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop.
  - Overflow and underflow are impossible by construction; assert this in simulation.
- BusWrValid = ~Empty. BusWrAdr and BusWrData come from entry rd_ptr.
- A store pushed into an empty buffer appears on BusWrValid in the next cycle (1-cycle latency).
- While BusWrValid & ~BusWrReady, BusWrAdr and BusWrData hold stable.
- Drain order is strictly FIFO.
- Forwarding (combinational):
  - Compare DataAdrM against every valid entry. An entry is valid when its offset from rd_ptr is below count.
  - If any entry matches, ReadDataM is the data of the youngest match, i.e. the one nearest wr_ptr-1. Otherwise ReadDataM = MemRdData.
  - An entry being popped in the current cycle still forwards.
  - A store being pushed in the current cycle does not forward; the core never issues a load and a store in the same cycle.
  - Forwarding is evaluated every cycle regardless of MemWriteM. The core ignores ReadDataM for non-loads.
- Address compare is full AW bits; no byte or halfword merging.
- No state machine beyond the FIFO pointers. Full, Empty and BusWrValid are decoded from count.

Decomposition:
- Shared package rv_mem_pkg: AW/DW defaults and a typedef for a store entry {adr, dat}.
- One natural sub-module: sb_fwd_match. It is a purely combinational youngest-match priority search over the entries, taking the entry arrays, rd_ptr, count and the lookup address, and returning hit and data.
- FIFO pointers and storage stay in store_buffer.

Test Plan:
- Reset hold: reset=0 for 2 cycles with MemWriteM=1 -> Empty=1, BusWrValid=0, count=0. After reset=1, the first store appears one cycle later.
- Single store drain: store adr 0x100 / data 0xDEADBEEF with BusWrReady=0 for 3 cycles, then 1 -> BusWrValid=1 with stable adr/data for 3 cycles. Pop occurs on cycle 4; Empty=1 afterwards.
- Forwarding youngest: with BusWrReady=0, store 0x200=0x11, 0x204=0x22, 0x200=0x33, then load 0x200 with MemRdData=0xAAAA -> ReadDataM=0x33. Load 0x208 -> ReadDataM=0xAAAA.
- Full and stall: DEPTH=4, BusWrReady=0, 5 back-to-back stores -> Full=1 after the 4th. On the 5th, StoreStall=1 and no entry is written. Raise BusWrReady with the 5th still held -> it is still stalled that cycle and accepted the next cycle.
- Wrap-around and push/pop overlap: BusWrReady=1 continuously and 10 consecutive stores to 0x0..0x24 -> count stays at 1. Drain order matches issue order; pointers wrap past index 3 with no loss.
- Reset mid-drain: 3 buffered stores, BusWrReady=0, assert reset=0 for one cycle -> BusWrValid=0 and Empty=1 next cycle. A subsequent load of a previously buffered address returns MemRdData.
